// File: rtl/spi_slave_bridge.sv
// -----------------------------------------------------------------------------
// spi_slave_bridge
// SPI mode-0 responder (MSB first) for the 12-bit {rw, addr, data} command
// protocol. Write frames become a single-cycle register write strobe; read
// frames issue a read request once rw and addr have arrived, then shift the
// returned register value back out on miso. sclk, cs and mosi are oversampled
// in the clk domain.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sclk, cs, mosi    asynchronous SPI pins from the master (cs active low)
//   miso, miso_oe     serial response and its drive enable
//   wr_vld/addr/data  one-cycle write strobe with address and data
//   rd_req/addr       one-cycle read request; rd_addr held until next request
//   rd_data           read data from the register side
//   busy              high while a frame is in progress
//   frame_err         one-cycle pulse when cs rises mid-frame
//
// Pipeline: pin -> sync ff1 -> sync ff2 -> history (edge acted on, cycle 3)
// -> output register (cycle 4).
// -----------------------------------------------------------------------------
module spi_slave_bridge #(
  parameter int CMD_WIDTH  = 12,
  parameter int ADDR_WIDTH = 3,
  parameter int READ_WIDTH = 8   // CMD_WIDTH must equal 1 + ADDR_WIDTH + READ_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  wr_vld,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [READ_WIDTH-1:0] wr_data,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [READ_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CNT_W    = $clog2(CMD_WIDTH + 1);
  localparam int HDR_BITS = 1 + ADDR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RESP, ST_DONE} state_t;

  state_t r_state, w_state_nxt;

  // Synchronizers and edge-detect history
  logic [1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic       r_sclk_hist, r_cs_hist;

  // Frame datapath (updated on the cycle an edge is acted on)
  logic [CMD_WIDTH-2:0]  r_cmd;  // rw bit is only needed combinationally
  logic [READ_WIDTH-1:0] r_tx;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_miso_bit;
  logic                  r_wr_fire, r_rd_fire, r_err_fire;

  logic                  w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall, w_mosi;
  logic [CMD_WIDTH-1:0]  w_cmd_shift;
  logic                  w_cnt_clr, w_cnt_inc, w_shift_cmd;
  logic                  w_load_tx, w_shift_tx;
  logic                  w_wr_fire, w_rd_fire, w_err_fire;

  // Synchronizer reset to 0: if cs is still low when reset releases, no fall
  // is seen, so a new frame needs a fresh cs fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_hist <= 1'b0;
      r_cs_hist   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_cs_sync   <= {r_cs_sync[0], cs};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_sclk_hist <= r_sclk_sync[1];
      r_cs_hist   <= r_cs_sync[1];
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_hist;
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_hist;
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_hist;
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_hist;
  assign w_mosi      = r_mosi_sync[1];
  assign w_cmd_shift = {r_cmd, w_mosi};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and control. cs edges are checked first so they win over an
  // sclk edge detected on the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_shift_cmd = 1'b0;
    w_load_tx   = 1'b0;
    w_shift_tx  = 1'b0;
    w_wr_fire   = 1'b0;
    w_rd_fire   = 1'b0;
    w_err_fire  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ST_CMD;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_CMD: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_err_fire  = 1'b1;
        end else if (w_sclk_rise) begin
          w_shift_cmd = 1'b1;
          w_cnt_inc   = 1'b1;
          // rw is bit HDR_BITS-1 of the shifter once the header has arrived
          if (r_cnt == CNT_W'(HDR_BITS - 1) && !w_cmd_shift[HDR_BITS-1])
            w_rd_fire = 1'b1;
          if (r_cnt == CNT_W'(CMD_WIDTH - 1)) begin
            if (w_cmd_shift[CMD_WIDTH-1]) begin
              w_wr_fire   = 1'b1;
              w_state_nxt = ST_DONE;
            end else begin
              w_load_tx   = 1'b1;
              w_cnt_clr   = 1'b1;
              w_cnt_inc   = 1'b0;
              w_state_nxt = ST_RESP;
            end
          end
        end
      end
      ST_RESP: begin
        if (w_cs_rise) begin
          w_state_nxt = ST_IDLE;
          w_err_fire  = 1'b1;
        end else begin
          if (w_sclk_fall) w_shift_tx = 1'b1;
          if (w_sclk_rise) begin
            w_cnt_inc = 1'b1;
            if (r_cnt == CNT_W'(READ_WIDTH - 1)) w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (w_cs_rise) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= '0;
      r_tx       <= '0;
      r_cnt      <= '0;
      r_miso_bit <= 1'b0;
      r_wr_fire  <= 1'b0;
      r_rd_fire  <= 1'b0;
      r_err_fire <= 1'b0;
    end else begin
      r_wr_fire  <= w_wr_fire;
      r_rd_fire  <= w_rd_fire;
      r_err_fire <= w_err_fire;

      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);

      if (w_cnt_clr && r_state == ST_IDLE) r_cmd <= '0;
      else if (w_shift_cmd)                r_cmd <= w_cmd_shift[CMD_WIDTH-2:0];

      if (w_load_tx)       r_tx <= rd_data;
      else if (w_shift_tx) r_tx <= {r_tx[READ_WIDTH-2:0], 1'b0};

      // miso stays low outside a response; in DONE the last bit is held
      if (w_state_nxt == ST_IDLE) r_miso_bit <= 1'b0;
      else if (w_shift_tx)        r_miso_bit <= r_tx[READ_WIDTH-1];
    end
  end

  // Output register stage. After the header shifts in, the address sits in the
  // low bits of r_cmd; after the full frame, addr/data occupy the low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      miso      <= r_miso_bit;
      miso_oe   <= (r_state != ST_IDLE);
      busy      <= (r_state != ST_IDLE);
      wr_vld    <= r_wr_fire;
      rd_req    <= r_rd_fire;
      frame_err <= r_err_fire;
      if (r_wr_fire) begin
        wr_addr <= r_cmd[CMD_WIDTH-2 -: ADDR_WIDTH];
        wr_data <= r_cmd[READ_WIDTH-1:0];
      end
      if (r_rd_fire) rd_addr <= r_cmd[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_spi_slave_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_bridge
// Drives SPI frames as the master would (all pin changes on the clk falling
// edge) and checks the register-bus side and the miso stream against queues
// of expected transactions filled by the stimulus.
// -----------------------------------------------------------------------------
module tb_spi_slave_bridge;

  localparam int HALF = 4;  // sclk half-period in clk cycles

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi;
  logic       miso, miso_oe, wr_vld, rd_req, busy, frame_err;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  xfer_t wr_q[$];
  xfer_t rd_q[$];
  bit    err_q[$];
  bit    miso_q[$];

  int  n_checks = 0;
  int  n_errors = 0;
  bit  sample_en = 1'b0;

  always #5 clk = ~clk;

  spi_slave_bridge dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_err(frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse();
    wait_clk(HALF);
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [11:0] cmd, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      mosi = cmd[11-i];
      sclk_pulse();
    end
    mosi = 1'b0;
  endtask

  task automatic write_frame(input logic [11:0] cmd, input int extra);
    xfer_t x;
    x = {cmd[10:8], cmd[7:0]};
    wr_q.push_back(x);
    cs = 1'b0;
    send_bits(cmd, 12);
    for (int i = 0; i < extra; i++) sclk_pulse();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic read_frame(input logic [11:0] cmd, input logic [7:0] data);
    xfer_t x;
    x = {cmd[10:8], data};
    rd_q.push_back(x);
    for (int i = 7; i >= 0; i--) miso_q.push_back(data[i]);
    cs = 1'b0;
    send_bits(cmd, 12);
    sample_en = 1'b1;
    for (int i = 0; i < 8; i++) sclk_pulse();
    sample_en = 1'b0;
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(HALF);
  endtask

  // Register-bus monitor: pops the expected transaction whenever the DUT
  // strobes, and answers read requests with rd_data two cycles later.
  initial begin : bus_monitor
    xfer_t      x;
    logic [7:0] rd_next;
    bit         rd_pend;
    rd_pend = 1'b0;
    rd_next = '0;
    forever begin
      @(negedge clk);
      if (rd_pend) begin
        rd_data = rd_next;
        rd_pend = 1'b0;
      end
      if (wr_vld) begin
        if (wr_q.size() == 0) unexpected("wr_vld");
        else begin
          x = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(x.addr));
          check("wr_data", 32'(wr_data), 32'(x.data));
        end
      end
      if (rd_req) begin
        if (rd_q.size() == 0) unexpected("rd_req");
        else begin
          x = rd_q.pop_front();
          check("rd_addr", 32'(rd_addr), 32'(x.addr));
          rd_data = ~x.data;  // wrong value until the promised stable point
          rd_next = x.data;
          rd_pend = 1'b1;
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) unexpected("frame_err");
        else void'(err_q.pop_front());
      end
    end
  end

  // miso monitor: the master samples miso on each response-phase sclk rise.
  initial begin : miso_monitor
    bit b;
    forever begin
      @(posedge sclk);
      if (sample_en) begin
        if (miso_q.size() == 0) unexpected("miso");
        else begin
          b = miso_q.pop_front();
          check("miso_bit", 32'(miso), 32'(b));
          check("miso_oe_rd", 32'(miso_oe), 32'd1);
        end
      end
    end
  end

  initial begin : stimulus
    logic [11:0] cmd;
    logic [7:0]  d;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; rd_data = '0;
    wait_clk(3);
    check("rst_miso", 32'(miso), 0);
    check("rst_miso_oe", 32'(miso_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr", {wr_vld, 5'd0, wr_addr, wr_data}, 0);
    check("rst_rd", {rd_req, rd_addr}, 0);
    check("rst_err", 32'(frame_err), 0);
    rst = 1'b0;
    wait_clk(5);

    // Write 0xBA5; busy must drop exactly 4 cycles after cs rises
    wr_q.push_back(xfer_t'({3'd3, 8'hA5}));
    cs = 1'b0;
    send_bits(12'hBA5, 12);
    check("busy_in_frame", 32'(busy), 1);
    check("oe_in_frame", 32'(miso_oe), 1);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(3);
    check("busy_hold_3", 32'(busy), 1);
    wait_clk(1);
    check("busy_drop_4", 32'(busy), 0);
    check("oe_drop_4", 32'(miso_oe), 0);
    wait_clk(HALF);

    // Read 0x500 -> addr 5, data 0x3C
    read_frame(12'h500, 8'h3C);
    wait_clk(4);

    // Abort after 7 bits of a write
    cs = 1'b0;
    send_bits(12'hBA5, 7);
    err_q.push_back(1'b1);
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(6);
    check("abort_busy", 32'(busy), 0);
    check("abort_oe", 32'(miso_oe), 0);
    check("abort_miso", 32'(miso), 0);
    wait_clk(4);

    // Reset after 9 bits of a write, then a clean frame
    cs = 1'b0;
    send_bits(12'hBA5, 9);
    rst = 1'b1;
    wait_clk(2);
    check("mrst_busy_oe", {busy, miso_oe, miso}, 0);
    check("mrst_wr", {wr_vld, 5'd0, wr_addr, wr_data}, 0);
    check("mrst_rd", {rd_req, rd_addr, frame_err}, 0);
    rst = 1'b0;
    wait_clk(2);
    cs = 1'b1;
    wait_clk(6);
    write_frame(12'h8FF, 0);

    // Write with extra clocks, minimum cs-high gap, then read 0x700 -> 0x81
    write_frame(12'h9AA, 3);
    read_frame(12'h700, 8'h81);
    wait_clk(4);

    // Minimum-rate random mix
    for (int n = 0; n < 100; n++) begin
      d   = 8'($urandom);
      cmd = {1'($urandom), 3'($urandom), 8'($urandom)};
      if (cmd[11]) write_frame(cmd, 0);
      else         read_frame(cmd, d);
    end

    wait_clk(20);
    check("wr_q_empty", 32'(wr_q.size()), 0);
    check("rd_q_empty", 32'(rd_q.size()), 0);
    check("err_q_empty", 32'(err_q.size()), 0);
    check("miso_q_empty", 32'(miso_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
